otl_pack_lanes: RTL and testbench
=================================

# otl_pack_lanes

Parametrised sample-to-word packer and successor to the fixed two-lane 12→32-bit packer. It accepts one narrow sample per handshake, extends each sample to a lane, and packs LANES samples into one output word, first sample in the most significant lane. A frame end can close a partial word, which is then flushed with lane-valid flags. A registered valid/ready output stage gives backpressure toward the ADC/DMA side.

## Interface
- SAMPLE_W, 12: input sample width; 1 ≤ SAMPLE_W ≤ LANE_W.
- LANE_W, 16: width of one lane in the output word.
- LANES, 2: samples per output word; ≥ 2. The lane pointer is $clog2(LANES) bits.
- SIGN_EXT, 0: 0 zero-extends a sample to LANE_W; 1 sign-extends from bit SAMPLE_W-1.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- data_i  in  SAMPLE_W  input sample.
- valid_i  in  1  data_i/last_i valid.
- last_i  in  1  sample is last of frame; qualified by valid_i.
- ready_o  out  1  block accepts a sample this cycle.
- data_o  out  LANES*LANE_W  packed word; lane k at bits [(LANES-k)*LANE_W-1 -: LANE_W].
- keep_o  out  LANES  bit LANES-1-k set when lane k holds a sample (MSB = lane 0).
- last_o  out  1  word closes a frame.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts word.

## Operation
- Accept: acc = valid_i & ready_o. ready_o = ~valid_o | ready_i. This is combinational from ready_i and valid_o, with no registered stall.
- Lane fill: on acc, the extended sample is written to lane lane_ptr of the accumulator.
- If lane_ptr == LANES-1 or last_i = 1, the word closes:
  - The accumulator, with the current sample merged in, loads the output register.
  - keep_o gets lanes 0..lane_ptr set; last_o = last_i.
  - valid_o = 1; lane_ptr returns to 0.
  - The accumulator clears to 0, so unfilled lanes of the next word are 0.
- Otherwise lane_ptr increments. The output register is unaffected except by drain.
- Drain: valid_o & ready_i with no close in the same cycle sets valid_o to 0. data_o, keep_o and last_o hold their values; they are don't-care while valid_o = 0.
- Simultaneous drain and close in one cycle: the new word replaces the old one and valid_o stays 1. No bubble, no loss.
- Unfilled lanes of a flushed word are 0 regardless of SIGN_EXT.
- last_i on a sample that also fills lane LANES-1 gives a full word: keep_o all ones, last_o = 1.
- States are implicit: lane_ptr (FILL 0..LANES-1) × output register (EMPTY/FULL). There are no other states.
- Reset (rst_n = 0 at a clock edge), including mid-word:
  - lane_ptr = 0; accumulator = 0; data_o = 0; keep_o = 0; last_o = 0; valid_o = 0.
  - The partial word is discarded.
  - ready_o evaluates to 1 after reset.
  - Samples presented during reset are not accepted.

## Timing
- Latency: the word is visible on valid_o in the cycle after the edge that accepts its closing sample.
- Throughput: one sample per cycle with ready_i held 1, giving one word every LANES cycles.
- ready_i = 0 with valid_o = 1: ready_o = 0; data_o, keep_o and last_o hold stable. The AXI-style rule applies: valid_o never drops without a handshake.
- No combinational path from valid_i or data_i to any output. The only comb path is ready_i → ready_o.

## Test plan
- Defaults (SAMPLE_W=12, LANE_W=16, LANES=2, SIGN_EXT=0):
  - Input: 0x123 then 0xABC, ready_i = 1.
  - Required: data_o = 0x01230ABC, keep_o = 2'b11, last_o = 0, valid_o high for exactly 1 cycle, one cycle after the second accept.
- SIGN_EXT=1, defaults otherwise:
  - Input: 0x800 then 0x7FF.
  - Required: data_o = 0xF80007FF.
- Partial flush:
  - Input: 0x123 with last_i = 1 as the first sample of a word.
  - Required: data_o = 0x01230000, keep_o = 2'b10, last_o = 1. The next word starts in lane 0.
- Backpressure:
  - Stimulus: stream 0x001..0x006 continuously; hold ready_i = 0 for 5 cycles after the first word is valid.
  - Required: ready_o = 0 while stalled; data_o stays 0x00010002.
  - After release: words 0x00030004 and 0x00050006 follow with no loss or duplication. A drain-and-close in the same cycle keeps valid_o = 1.
- LANES=4, LANE_W=12, SAMPLE_W=12:
  - Input: 0x111, 0x222, 0x333, 0x444, 0x555 (last_i = 1).
  - Required: 0x111222333444 with keep_o = 4'b1111, then 0x555000000000 with keep_o = 4'b1000 and last_o = 1.
- Reset mid-word:
  - Stimulus: accept 0x123; pull rst_n low for 1 cycle; then send 0x456, 0x789.
  - Required: all outputs 0 during reset; the next word is 0x04560789 with keep_o = 2'b11. 0x123 never appears.

Source files
------------

// File: rtl/otl_pack_lanes.sv
// Sample-to-word packer: extends narrow samples to lanes and packs LANES of them
// per output word (first sample in the MS lane), with frame-end partial flush.
module otl_pack_lanes #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned LANE_W   = 16,
  parameter int unsigned LANES    = 2,
  parameter int unsigned SIGN_EXT = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SAMPLE_W-1:0]       data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      ready_o,
  output logic [LANES*LANE_W-1:0]   data_o,
  output logic [LANES-1:0]          keep_o,
  output logic                      last_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int unsigned PTR_W  = $clog2(LANES);
  localparam int unsigned WORD_W = LANES * LANE_W;

  logic [PTR_W-1:0]  lane_ptr;
  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] merged;
  logic [LANE_W-1:0] ext;
  logic [LANES-1:0]  keep_next;
  logic              acc_en;
  logic              close;

  always_comb begin
    ext = LANE_W'(data_i);
    if (SIGN_EXT != 0) begin
      for (int unsigned i = SAMPLE_W; i < LANE_W; i++) begin
        ext[i] = data_i[SAMPLE_W-1];
      end
    end
  end

  // Current sample merged into the accumulator so a closing word can load in one edge.
  always_comb begin
    merged    = acc_q;
    keep_next = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_ptr == PTR_W'(k)) begin
        merged[(LANES-1-k)*LANE_W +: LANE_W] = ext;
      end
      keep_next[LANES-1-k] = (PTR_W'(k) <= lane_ptr);
    end
  end

  assign ready_o = ~valid_o | ready_i;
  assign acc_en  = valid_i & ready_o;
  assign close   = acc_en & ((lane_ptr == PTR_W'(LANES-1)) | last_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_ptr <= '0;
      acc_q    <= '0;
      data_o   <= '0;
      keep_o   <= '0;
      last_o   <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      if (valid_o && ready_i && !close) begin
        valid_o <= 1'b0;
      end
      if (acc_en) begin
        if (close) begin
          data_o   <= merged;
          keep_o   <= keep_next;
          last_o   <= last_i;
          valid_o  <= 1'b1;
          acc_q    <= '0;
          lane_ptr <= '0;
        end else begin
          acc_q    <= merged;
          lane_ptr <= lane_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_otl_pack_lanes.sv
// Directed bench for otl_pack_lanes: default, sign-extending and 4-lane builds.
module tb_otl_pack_lanes;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  // default build
  logic [11:0] d_data;
  logic        d_valid, d_last, d_rdy_i;
  logic        d_rdy_o, d_last_o, d_valid_o;
  logic [31:0] d_data_o;
  logic [1:0]  d_keep_o;

  // sign-extending build
  logic [11:0] s_data;
  logic        s_valid, s_last, s_rdy_i;
  logic        s_rdy_o, s_last_o, s_valid_o;
  logic [31:0] s_data_o;
  logic [1:0]  s_keep_o;

  // four-lane build
  logic [11:0] q_data;
  logic        q_valid, q_last, q_rdy_i;
  logic        q_rdy_o, q_last_o, q_valid_o;
  logic [47:0] q_data_o;
  logic [3:0]  q_keep_o;

  otl_pack_lanes u_def (
    .clk(clk), .rst_n(rst_n), .data_i(d_data), .valid_i(d_valid), .last_i(d_last),
    .ready_o(d_rdy_o), .data_o(d_data_o), .keep_o(d_keep_o), .last_o(d_last_o),
    .valid_o(d_valid_o), .ready_i(d_rdy_i)
  );

  otl_pack_lanes #(.SIGN_EXT(1)) u_sx (
    .clk(clk), .rst_n(rst_n), .data_i(s_data), .valid_i(s_valid), .last_i(s_last),
    .ready_o(s_rdy_o), .data_o(s_data_o), .keep_o(s_keep_o), .last_o(s_last_o),
    .valid_o(s_valid_o), .ready_i(s_rdy_i)
  );

  otl_pack_lanes #(.SAMPLE_W(12), .LANE_W(12), .LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .data_i(q_data), .valid_i(q_valid), .last_i(q_last),
    .ready_o(q_rdy_o), .data_o(q_data_o), .keep_o(q_keep_o), .last_o(q_last_o),
    .valid_o(q_valid_o), .ready_i(q_rdy_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    d_data = 12'h3FF; d_valid = 1'b1; d_last = 1'b0; d_rdy_i = 1'b1;
    s_data = 12'h000; s_valid = 1'b0; s_last = 1'b0; s_rdy_i = 1'b1;
    q_data = 12'h000; q_valid = 1'b0; q_last = 1'b0; q_rdy_i = 1'b1;
    @(negedge clk);
    step();
    chk("rst_valid", 64'(d_valid_o), 64'h0);
    chk("rst_data",  64'(d_data_o),  64'h0);
    chk("rst_keep",  64'(d_keep_o),  64'h0);
    chk("rst_last",  64'(d_last_o),  64'h0);
    chk("rst_ready", 64'(d_rdy_o),   64'h1);
    rst_n = 1'b1; d_valid = 1'b0;
    step();
    chk("rst_no_accept", 64'(d_valid_o), 64'h0);

    // two-sample word
    d_valid = 1'b1; d_data = 12'h123;
    step();
    chk("w1_not_yet", 64'(d_valid_o), 64'h0);
    d_data = 12'hABC;
    step();
    chk("w1_valid", 64'(d_valid_o), 64'h1);
    chk("w1_data",  64'(d_data_o),  64'h01230ABC);
    chk("w1_keep",  64'(d_keep_o),  64'h3);
    chk("w1_last",  64'(d_last_o),  64'h0);
    d_valid = 1'b0;
    step();
    chk("w1_one_cycle", 64'(d_valid_o), 64'h0);

    // partial flush, then next word starts in lane 0
    d_valid = 1'b1; d_data = 12'h123; d_last = 1'b1;
    step();
    chk("pf_valid", 64'(d_valid_o), 64'h1);
    chk("pf_data",  64'(d_data_o),  64'h01230000);
    chk("pf_keep",  64'(d_keep_o),  64'h2);
    chk("pf_last",  64'(d_last_o),  64'h1);
    d_data = 12'h456; d_last = 1'b0;
    step();
    chk("pf_drain", 64'(d_valid_o), 64'h0);
    d_data = 12'h789;
    step();
    chk("pf_next_data", 64'(d_data_o), 64'h04560789);
    chk("pf_next_keep", 64'(d_keep_o), 64'h3);

    // drain and close on the same edge: back-to-back single-sample frames
    d_data = 12'h00A; d_last = 1'b1;
    step();
    chk("dc_first", 64'(d_data_o), 64'h000A0000);
    d_data = 12'h00B;
    step();
    chk("dc_valid", 64'(d_valid_o), 64'h1);
    chk("dc_data",  64'(d_data_o),  64'h000B0000);
    d_valid = 1'b0; d_last = 1'b0;
    step();

    // backpressure
    d_valid = 1'b1; d_data = 12'h001;
    step();
    d_data = 12'h002;
    step();
    chk("bp_w1", 64'(d_data_o), 64'h00010002);
    d_data = 12'h003; d_rdy_i = 1'b0;
    #1;
    chk("bp_ready_low", 64'(d_rdy_o), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_stall_ready", 64'(d_rdy_o),   64'h0);
      chk("bp_stall_valid", 64'(d_valid_o), 64'h1);
      chk("bp_stall_data",  64'(d_data_o),  64'h00010002);
    end
    d_rdy_i = 1'b1;
    step();
    chk("bp_rel_drain", 64'(d_valid_o), 64'h0);
    d_data = 12'h004;
    step();
    chk("bp_w2_valid", 64'(d_valid_o), 64'h1);
    chk("bp_w2_data",  64'(d_data_o),  64'h00030004);
    d_data = 12'h005;
    step();
    chk("bp_gap", 64'(d_valid_o), 64'h0);
    d_data = 12'h006;
    step();
    chk("bp_w3_valid", 64'(d_valid_o), 64'h1);
    chk("bp_w3_data",  64'(d_data_o),  64'h00050006);
    d_valid = 1'b0;
    step();
    chk("bp_no_dup", 64'(d_valid_o), 64'h0);

    // sign extension, and zero fill of an unfilled lane
    s_valid = 1'b1; s_data = 12'h800;
    step();
    s_data = 12'h7FF;
    step();
    chk("sx_data", 64'(s_data_o), 64'hF80007FF);
    s_data = 12'h800; s_last = 1'b1;
    step();
    chk("sx_flush_data", 64'(s_data_o), 64'hF8000000);
    chk("sx_flush_keep", 64'(s_keep_o), 64'h2);
    s_valid = 1'b0; s_last = 1'b0;
    step();

    // four lanes
    q_valid = 1'b1;
    q_data = 12'h111; step();
    q_data = 12'h222; step();
    q_data = 12'h333; step();
    chk("l4_not_yet", 64'(q_valid_o), 64'h0);
    q_data = 12'h444; step();
    chk("l4_w1_data", 64'(q_data_o), 64'h111222333444);
    chk("l4_w1_keep", 64'(q_keep_o), 64'hF);
    chk("l4_w1_last", 64'(q_last_o), 64'h0);
    q_data = 12'h555; q_last = 1'b1; step();
    chk("l4_w2_valid", 64'(q_valid_o), 64'h1);
    chk("l4_w2_data",  64'(q_data_o),  64'h555000000000);
    chk("l4_w2_keep",  64'(q_keep_o),  64'h8);
    chk("l4_w2_last",  64'(q_last_o),  64'h1);
    q_valid = 1'b0; q_last = 1'b0; step();
    chk("l4_drain", 64'(q_valid_o), 64'h0);

    // reset mid-word discards the partial sample
    d_valid = 1'b1; d_data = 12'h123;
    step();
    rst_n = 1'b0; d_data = 12'h3FF;
    step();
    chk("mr_valid", 64'(d_valid_o), 64'h0);
    chk("mr_data",  64'(d_data_o),  64'h0);
    chk("mr_keep",  64'(d_keep_o),  64'h0);
    chk("mr_last",  64'(d_last_o),  64'h0);
    chk("mr_ready", 64'(d_rdy_o),   64'h1);
    rst_n = 1'b1; d_data = 12'h456;
    step();
    chk("mr_after_one", 64'(d_valid_o), 64'h0);
    d_data = 12'h789;
    step();
    chk("mr_word_valid", 64'(d_valid_o), 64'h1);
    chk("mr_word_data",  64'(d_data_o),  64'h04560789);
    chk("mr_word_keep",  64'(d_keep_o),  64'h3);
    d_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
